dco_code_slewer: RTL

- Registered, slew-limited sequencer that sits directly upstream of the row/column binary-to-thermometer decoders of the FLB DCO capacitor matrix.
- Accepts an 8-bit tuning code from the loop filter through a valid/ready handshake.
- Walks the applied code toward the target by at most STEP LSBs per clock, then holds off new requests for a settling interval.
- Drives the row field, column field and odd-row flag consumed by the decoders.

---
 rtl/dco_code_pkg.sv | 27 ++
 rtl/dco_code_slewer.sv | 97 +++++++++
 2 files changed

// File: rtl/dco_code_pkg.sv
// Shared types and helpers for the DCO capacitor-matrix code path.
// Splits an 8-bit tuning code into the row/column fields used by the decoders.
package dco_code_pkg;

    localparam int unsigned CODE_W = 8;
    localparam int unsigned ROW_W  = 4;
    localparam int unsigned COL_W  = 4;

    typedef enum logic [1:0] {
        IDLE,
        SLEW,
        SETTLE
    } slew_state_t;

    typedef struct packed {
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
    } code_fields_t;

    function automatic code_fields_t split_code(input logic [CODE_W-1:0] code);
        code_fields_t f;
        f.row = code[CODE_W-1 -: ROW_W];
        f.col = code[COL_W-1:0];
        return f;
    endfunction

endpackage

// File: rtl/dco_code_slewer.sv
// Slew-limited tuning-code sequencer feeding the DCO row/column decoders.
// Walks the applied code toward an accepted target, then settles before the next request.
module dco_code_slewer
    import dco_code_pkg::*;
#(
    parameter int unsigned STEP       = 1,
    parameter int unsigned SETTLE_CYC = 4,
    parameter int unsigned RST_CODE   = 128
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [7:0]        code_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic [3:0]        row_o,
    output logic [3:0]        col_o,
    output logic              oc_o,
    output logic              upd_o,
    output logic              busy_o
);

    localparam int unsigned       CNT_W    = $clog2(SETTLE_CYC) + 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CODE_W-1:0] RST_C    = CODE_W'(RST_CODE);
    localparam logic [CODE_W-1:0] STEP_C   = CODE_W'(STEP);

    slew_state_t       state_q;
    logic [CODE_W-1:0] cur_q;
    logic [CODE_W-1:0] tgt_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              upd_q;

    logic [CODE_W:0]   diff_d;
    logic [CODE_W-1:0] step_d;
    logic [CODE_W-1:0] cur_d;
    logic              up_d;
    code_fields_t      fields;

    // Step is clipped to the remaining distance, so cur can never overshoot or wrap.
    always_comb begin
        up_d   = (tgt_q >= cur_q);
        diff_d = up_d ? ({1'b0, tgt_q} - {1'b0, cur_q})
                      : ({1'b0, cur_q} - {1'b0, tgt_q});
        step_d = (diff_d < {1'b0, STEP_C}) ? diff_d[CODE_W-1:0] : STEP_C;
        cur_d  = up_d ? (cur_q + step_d) : (cur_q - step_d);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cur_q   <= RST_C;
            tgt_q   <= RST_C;
            cnt_q   <= '0;
            upd_q   <= 1'b0;
        end else begin
            upd_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (valid_i) begin
                        tgt_q   <= code_i;
                        state_q <= SLEW;
                    end
                end
                SLEW: begin
                    if (cur_q == tgt_q) begin
                        state_q <= SETTLE;
                        cnt_q   <= CNT_LOAD;
                    end else begin
                        cur_q <= cur_d;
                        upd_q <= 1'b1;
                        if (cur_d == tgt_q) begin
                            state_q <= SETTLE;
                            cnt_q   <= CNT_LOAD;
                        end
                    end
                end
                SETTLE: begin
                    if (cnt_q == '0) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign fields  = split_code(cur_q);
    assign row_o   = fields.row;
    assign col_o   = fields.col;
    assign oc_o    = cur_q[COL_W];
    assign upd_o   = upd_q;
    assign ready_o = (state_q == IDLE);
    assign busy_o  = (state_q != IDLE);

endmodule
